// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: write-back inputs, ID read ports, forwarding and count outputs.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              RegWriteI;
  logic              MemtoRegI;
  logic [DATA_W-1:0] DataMemRDI;
  logic [DATA_W-1:0] ALUResultI;
  logic [ADDR_W-1:0] WNI;
  logic [ADDR_W-1:0] RN1;
  logic [ADDR_W-1:0] RN2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [DATA_W-1:0] WDO;
  logic [CNT_W-1:0]  WBCount;

  modport master (
    output RegWriteI, MemtoRegI, DataMemRDI, ALUResultI, WNI, RN1, RN2,
    input  RD1, RD2, WDO, WBCount
  );

  modport slave (
    input  RegWriteI, MemtoRegI, DataMemRDI, ALUResultI, WNI, RN1, RN2,
    output RD1, RD2, WDO, WBCount
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select, 2^ADDR_W x DATA_W register file with $zero, and commit counter.
// Optional macro WB_BYPASS_EN: reads of the register being written return the new data same-cycle.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0]           wd;
  logic                        commit;
  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [CNT_W-1:0]            cnt;
  logic [DATA_W-1:0]           rd1, rd2;

  assign wd      = bus.MemtoRegI ? bus.DataMemRDI : bus.ALUResultI;
  assign commit  = bus.RegWriteI && (bus.WNI != '0);
  assign bus.WDO = wd;
  assign bus.WBCount = cnt;
  assign bus.RD1 = rd1;
  assign bus.RD2 = rd2;

  // Entry 0 is never written, so it holds the reset zero; reads still force 0 below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
      cnt  <= '0;
    end else if (commit) begin
      regs[bus.WNI] <= wd;
      cnt           <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    rd1 = regs[bus.RN1];
    rd2 = regs[bus.RN2];
`ifdef WB_BYPASS_EN
    if (commit && (bus.WNI == bus.RN1)) rd1 = wd;
    if (commit && (bus.WNI == bus.RN2)) rd2 = wd;
`else
    // Pre-write contents; the hazard unit covers the extra distance.
`endif
    if (bus.RN1 == '0) rd1 = '0;
    if (bus.RN2 == '0) rd2 = '0;
  end
endmodule
